// File: rtl/group_mac_pkg.sv
// Shared widths and lane types for the 8-lane multiply-accumulate group.
package group_mac_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned PROD_W  = 16;
    localparam int unsigned PSUM_W  = 24;
    localparam int unsigned N_LANES = 8;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [PSUM_W-1:0] psum_t;

    // Zero-extend a lane product into the partial-sum domain.
    function automatic psum_t widen_prod(input prod_t p);
        return PSUM_W'(p);
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One unsigned 8x8 multiplier lane with a registered activation forward.
module mac_lane
    import group_mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] activation,
    output logic [PROD_W-1:0] product_c,
    output logic [DATA_W-1:0] next_activation
);

    data_t act_d;
    data_t act_q;

    always_comb begin
        product_c = PROD_W'(weight) * PROD_W'(activation);
        act_d     = activation;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_q <= '0;
        end else begin
            act_q <= act_d;
        end
    end

    assign next_activation = act_q;

endmodule

// File: rtl/group_8_mac.sv
// Eight-lane MAC group: adder tree over lane products plus deferred-product compensation.
// Error compensation is enabled by defining ERR_COMP_EN; otherwise the error ports are ignored.
module group_8_mac
    import group_mac_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  weight_1,
    input  logic [7:0]  weight_2,
    input  logic [7:0]  weight_3,
    input  logic [7:0]  weight_4,
    input  logic [7:0]  weight_5,
    input  logic [7:0]  weight_6,
    input  logic [7:0]  weight_7,
    input  logic [7:0]  weight_8,
    input  logic [7:0]  activation_1,
    input  logic [7:0]  activation_2,
    input  logic [7:0]  activation_3,
    input  logic [7:0]  activation_4,
    input  logic [7:0]  activation_5,
    input  logic [7:0]  activation_6,
    input  logic [7:0]  activation_7,
    input  logic [7:0]  activation_8,
    input  logic [23:0] partial_sum_in,
    input  logic [15:0] error_product_in,
    input  logic        error_in,
    input  logic        timing_err,
    output logic [7:0]  next_activation_1,
    output logic [7:0]  next_activation_2,
    output logic [7:0]  next_activation_3,
    output logic [7:0]  next_activation_4,
    output logic [7:0]  next_activation_5,
    output logic [7:0]  next_activation_6,
    output logic [7:0]  next_activation_7,
    output logic [7:0]  next_activation_8,
    output logic [23:0] partial_sum_out,
    output logic [15:0] error_product_out,
    output logic        error_out
);

    data_t w_a    [N_LANES];
    data_t a_a    [N_LANES];
    data_t na_a   [N_LANES];
    prod_t prod_c [N_LANES];

    assign w_a[0] = weight_1;
    assign w_a[1] = weight_2;
    assign w_a[2] = weight_3;
    assign w_a[3] = weight_4;
    assign w_a[4] = weight_5;
    assign w_a[5] = weight_6;
    assign w_a[6] = weight_7;
    assign w_a[7] = weight_8;

    assign a_a[0] = activation_1;
    assign a_a[1] = activation_2;
    assign a_a[2] = activation_3;
    assign a_a[3] = activation_4;
    assign a_a[4] = activation_5;
    assign a_a[5] = activation_6;
    assign a_a[6] = activation_7;
    assign a_a[7] = activation_8;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        mac_lane u_lane (
            .clk             (clk),
            .rst_n           (rst_n),
            .weight          (w_a[i]),
            .activation      (a_a[i]),
            .product_c       (prod_c[i]),
            .next_activation (na_a[i])
        );
    end

    psum_t psum_d;
    psum_t psum_q;
    prod_t eprod_d;
    prod_t eprod_q;
    logic  eout_d;
    logic  eout_q;

`ifndef ERR_COMP_EN
    logic unused_err_c;
    assign unused_err_c = ^{error_in, error_product_in, timing_err};
`endif

    // Lanes 1..7 always accumulate; lane 8 may be deferred downstream.
    always_comb begin
        psum_d  = partial_sum_in;
        eprod_d = '0;
        eout_d  = 1'b0;
        for (int unsigned i = 0; i < N_LANES - 1; i++) begin
            psum_d = psum_d + widen_prod(prod_c[i]);
        end
`ifdef ERR_COMP_EN
        if (!timing_err) begin
            psum_d = psum_d + widen_prod(prod_c[N_LANES-1]);
        end
        if (error_in) begin
            psum_d = psum_d + widen_prod(error_product_in);
        end
        eprod_d = timing_err ? prod_c[N_LANES-1] : '0;
        eout_d  = timing_err;
`else
        psum_d = psum_d + widen_prod(prod_c[N_LANES-1]);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psum_q  <= '0;
            eprod_q <= '0;
            eout_q  <= 1'b0;
        end else begin
            psum_q  <= psum_d;
            eprod_q <= eprod_d;
            eout_q  <= eout_d;
        end
    end

    assign partial_sum_out   = psum_q;
    assign error_product_out = eprod_q;
    assign error_out         = eout_q;

    assign next_activation_1 = na_a[0];
    assign next_activation_2 = na_a[1];
    assign next_activation_3 = na_a[2];
    assign next_activation_4 = na_a[3];
    assign next_activation_5 = na_a[4];
    assign next_activation_6 = na_a[5];
    assign next_activation_7 = na_a[6];
    assign next_activation_8 = na_a[7];

endmodule

// File: tb/tb_group_8_mac.sv
// Directed table-driven bench for group_8_mac; expectations follow the ERR_COMP_EN build setting.
module tb_group_8_mac;

    logic        clk;
    logic        rst_n;
    logic [7:0]  w [8];
    logic [7:0]  a [8];
    logic [23:0] partial_sum_in;
    logic [15:0] error_product_in;
    logic        error_in;
    logic        timing_err;
    logic [7:0]  na [8];
    logic [23:0] partial_sum_out;
    logic [15:0] error_product_out;
    logic        error_out;

    int checks;
    int errors;

    group_8_mac dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .weight_1          (w[0]),
        .weight_2          (w[1]),
        .weight_3          (w[2]),
        .weight_4          (w[3]),
        .weight_5          (w[4]),
        .weight_6          (w[5]),
        .weight_7          (w[6]),
        .weight_8          (w[7]),
        .activation_1      (a[0]),
        .activation_2      (a[1]),
        .activation_3      (a[2]),
        .activation_4      (a[3]),
        .activation_5      (a[4]),
        .activation_6      (a[5]),
        .activation_7      (a[6]),
        .activation_8      (a[7]),
        .partial_sum_in    (partial_sum_in),
        .error_product_in  (error_product_in),
        .error_in          (error_in),
        .timing_err        (timing_err),
        .next_activation_1 (na[0]),
        .next_activation_2 (na[1]),
        .next_activation_3 (na[2]),
        .next_activation_4 (na[3]),
        .next_activation_5 (na[4]),
        .next_activation_6 (na[5]),
        .next_activation_7 (na[6]),
        .next_activation_8 (na[7]),
        .partial_sum_out   (partial_sum_out),
        .error_product_out (error_product_out),
        .error_out         (error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  wv [8];
        logic [7:0]  av [8];
        logic [23:0] psum;
        logic [15:0] eprod;
        logic        ein;
        logic        terr;
        logic [23:0] exp_psum;
        logic [15:0] exp_eprod;
        logic        exp_eout;
    } vec_t;

    vec_t vecs [8];

`ifdef ERR_COMP_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            w[i] = v.wv[i];
            a[i] = v.av[i];
        end
        partial_sum_in   = v.psum;
        error_product_in = v.eprod;
        error_in         = v.ein;
        timing_err       = v.terr;
    endtask

    task automatic check_outputs(input string name, input logic [23:0] ep, input logic [15:0] ee,
                                 input logic eo, input vec_t src);
        check({name, ".psum"}, partial_sum_out, ep);
        check({name, ".eprod"}, 24'(error_product_out), 24'(ee));
        check({name, ".eout"}, 24'(error_out), 24'(eo));
        for (int i = 0; i < 8; i++)
            check($sformatf("%s.next_act%0d", name, i + 1), 24'(na[i]), 24'(src.av[i]));
    endtask

    task automatic set_pattern(output logic [7:0] wv [8], output logic [7:0] av [8], input int kind);
        for (int i = 0; i < 8; i++) begin
            case (kind)
                0: begin wv[i] = 8'(2 * i + 1);  av[i] = 8'(2 * i + 2);  end
                1: begin wv[i] = 8'(16 - 2 * i); av[i] = 8'(15 - 2 * i); end
                2: begin wv[i] = 8'hFF;          av[i] = 8'hFF;          end
                default: begin wv[i] = 8'h00;    av[i] = 8'h00;          end
            endcase
        end
    endtask

    task automatic fill(input int idx, input string name, input int kind, input logic [23:0] psum,
                        input logic [15:0] eprod, input logic ein, input logic terr,
                        input logic [23:0] exp_psum, input logic [15:0] exp_eprod, input logic exp_eout);
        vec_t v;
        set_pattern(v.wv, v.av, kind);
        v.name = name; v.psum = psum; v.eprod = eprod; v.ein = ein; v.terr = terr;
        v.exp_psum = exp_psum; v.exp_eprod = exp_eprod; v.exp_eout = exp_eout;
        vecs[idx] = v;
    endtask

    initial begin
        vec_t zero_v;
        checks = 0;
        errors = 0;

        // Pattern 0 products sum to 744 (lane 8 = 0xF0); pattern 1 also sums to 744; 0xFF*0xFF = 0xFE01.
        fill(0, "base",       0, 24'h008000, 16'h0000, 1'b0, 1'b0, 24'h0082E8, 16'h0000, 1'b0);
        fill(1, "ein0",       1, 24'h000008, 16'h0012, 1'b0, 1'b0, 24'h0002F0, 16'h0000, 1'b0);
        fill(2, "ein1",       1, 24'h000008, 16'h0012, 1'b1, 1'b0,
             COMP ? 24'h000302 : 24'h0002F0, 16'h0000, 1'b0);
        fill(3, "terr",       0, 24'h008000, 16'h0000, 1'b0, 1'b1,
             COMP ? 24'h0081F8 : 24'h0082E8, COMP ? 16'h00F0 : 16'h0000, COMP);
        fill(4, "wrap",       2, 24'hFFFFFF, 16'h0000, 1'b0, 1'b0, 24'h07F007, 16'h0000, 1'b0);
        fill(5, "both",       0, 24'h008000, 16'h0012, 1'b1, 1'b1,
             COMP ? 24'h00820A : 24'h0082E8, COMP ? 16'h00F0 : 16'h0000, COMP);
        fill(6, "ignore_ep",  3, 24'hABCDEF, 16'hFFFF, 1'b0, 1'b0, 24'hABCDEF, 16'h0000, 1'b0);
        fill(7, "wrap_terr",  2, 24'hFFFFFF, 16'h0000, 1'b0, 1'b1,
             COMP ? 24'h06F206 : 24'h07F007, COMP ? 16'hFE01 : 16'h0000, COMP);

        // Reset with non-zero inputs applied: everything must read zero.
        rst_n = 1'b0;
        drive(vecs[0]);
        @(posedge clk); #1;
        set_pattern(zero_v.wv, zero_v.av, 3);
        check_outputs("reset", 24'h0, 16'h0, 1'b0, zero_v);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            drive(vecs[k]);
            @(posedge clk); #1;
            check_outputs(vecs[k].name, vecs[k].exp_psum, vecs[k].exp_eprod, vecs[k].exp_eout, vecs[k]);
        end

        // Back-to-back vectors: each edge must reflect only the vector sampled at it.
        drive(vecs[3]);
        @(posedge clk); #1;
        check_outputs("b2b_a", vecs[3].exp_psum, vecs[3].exp_eprod, vecs[3].exp_eout, vecs[3]);
        drive(vecs[4]);
        @(posedge clk); #1;
        check_outputs("b2b_b", vecs[4].exp_psum, vecs[4].exp_eprod, vecs[4].exp_eout, vecs[4]);

        // Mid-stream reset discards sampled inputs, then results resume one edge after release.
        drive(vecs[7]);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_outputs("midrst", 24'h0, 16'h0, 1'b0, zero_v);
        rst_n = 1'b1;
        drive(vecs[0]);
        @(posedge clk); #1;
        check_outputs("resume", vecs[0].exp_psum, vecs[0].exp_eprod, vecs[0].exp_eout, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
